// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write-port arbiter.
//               Holds the controller state encoding, the statistics counter
//               width and a constant-evaluable ceil(log2) helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  // Controller state encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of each per-requester beat counter.
  localparam int STAT_W = 16;

  // ceil(log2(value)); clog2(1) returns 0, callers clamp where needed.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               upward starting at last_grant+1 (wrapping modulo Num_Req)
//               and returns the first set index.
// Ports       : req        - request vector, one bit per requester
//               last_grant - index of the most recent grantee
//               any        - high when at least one request bit is set
//               index      - selected requester (last_grant when any = 0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int Num_Req = 4,
  parameter int Id_W    = 2
) (
  input  logic [Num_Req-1:0] req,
  input  logic [Id_W-1:0]    last_grant,
  output logic               any,
  output logic [Id_W-1:0]    index
);

  always_comb begin
    int cand;
    logic hit;
    any   = 1'b0;
    index = last_grant;
    cand  = 0;
    hit   = 1'b0;
    // Offsets 1..Num_Req visit every requester once, with last_grant itself
    // checked last so it only wins when nobody else is asking.
    for (int k = 1; k <= Num_Req; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= Num_Req) begin
        cand = cand - Num_Req;
      end
      hit = 1'b0;
      for (int i = 0; i < Num_Req; i++) begin
        if (req[i] && (i == cand)) begin
          hit = 1'b1;
        end
      end
      if (hit && !any) begin
        any   = 1'b1;
        index = Id_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares one FIFO write port between Num_Req producers. Grants
//               round-robin in bursts of up to Burst_Max beats, honours
//               fifo_full backpressure without a register stage, and leaves
//               exactly one IDLE cycle between bursts.
// Ports       : Clk, Rst_n          - clock, asynchronous active-low reset
//               req_valid/req_data  - producer side (data flattened by index)
//               req_ready           - per-producer accept (grantee only)
//               fifo_full           - FIFO backpressure
//               wr_en/fifo_in       - FIFO write port
//               grant_id, busy      - current/last grantee, BURST indicator
//               stat_sel/stat_count - per-requester beat counter readback
// Options     : define FIFO_ARB_STATS_EN to build the 16-bit saturating beat
//               counters; otherwise stat_count reads 0 and stat_sel is unused.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int Width     = 8,
  parameter int Num_Req   = 4,
  parameter int Burst_Max = 4
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [Num_Req-1:0]         req_valid,
  input  logic [Num_Req*Width-1:0]   req_data,
  output logic [Num_Req-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       wr_en,
  output logic [Width-1:0]           fifo_in,
  output logic [clog2(Num_Req)-1:0]  grant_id,
  output logic                       busy,
  input  logic [clog2(Num_Req)-1:0]  stat_sel,
  output logic [STAT_W-1:0]          stat_count
);

  localparam int ID_W   = clog2(Num_Req);
  localparam int BEAT_W = (clog2(Burst_Max + 1) < 1) ? 1 : clog2(Burst_Max + 1);

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_BURST = ST_BURST;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [0:0]        state_q,      state_d;
  logic [ID_W-1:0]   grant_id_q,   grant_id_d;
  logic [BEAT_W-1:0] beat_cnt_q,   beat_cnt_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;

  // --------------------------------------------------------------------------
  // Grantee selection and transfer qualification
  // --------------------------------------------------------------------------
  logic             w_in_burst;
  logic             w_valid_g;
  logic [Width-1:0] w_data_g;
  logic             w_xfer;
  logic             w_last_beat;
  logic             w_pick_any;
  logic [ID_W-1:0]  w_pick_idx;

  always_comb begin
    w_valid_g = 1'b0;
    w_data_g  = '0;
    for (int i = 0; i < Num_Req; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        w_valid_g = req_valid[i];
        w_data_g  = req_data[i*Width +: Width];
      end
    end
  end

  assign w_in_burst  = (state_q == S_BURST);
  assign w_xfer      = w_in_burst && w_valid_g && !fifo_full;
  assign w_last_beat = (beat_cnt_q == BEAT_W'(Burst_Max - 1));

  rr_pick #(
    .Num_Req (Num_Req),
    .Id_W    (ID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any        (w_pick_any),
    .index      (w_pick_idx)
  );

  // --------------------------------------------------------------------------
  // Outputs: purely combinational from state and live inputs, so fifo_full
  // gates wr_en in the same cycle it is asserted.
  // --------------------------------------------------------------------------
  assign wr_en    = w_xfer;
  assign busy     = w_in_burst;
  assign fifo_in  = w_in_burst ? w_data_g : '0;
  assign grant_id = grant_id_q;

  for (genvar gi = 0; gi < Num_Req; gi++) begin : g_ready
    assign req_ready[gi] = w_in_burst && (grant_id_q == ID_W'(gi)) && !fifo_full;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (w_pick_any) begin
          grant_id_d = w_pick_idx;
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (!w_valid_g) begin
          // Grantee withdrew: release the port immediately.
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end else if (!fifo_full) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (w_last_beat) begin
            last_grant_d = grant_id_q;
            state_d      = S_IDLE;
          end
        end
        // valid with fifo_full is a stall: everything holds.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_grant resets to the top index so requester 0 is scanned first.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      last_grant_q <= ID_W'(Num_Req - 1);
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional per-requester beat statistics
  // --------------------------------------------------------------------------
`ifdef FIFO_ARB_STATS_EN
  logic [Num_Req*STAT_W-1:0] w_stat_flat;

  for (genvar gs = 0; gs < Num_Req; gs++) begin : g_stat_ctr
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (w_xfer && (grant_id_q == ID_W'(gs)) && (cnt_q != {STAT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign w_stat_flat[gs*STAT_W +: STAT_W] = cnt_q;
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < Num_Req; i++) begin
      if (stat_sel == ID_W'(i)) begin
        stat_count = w_stat_flat[i*STAT_W +: STAT_W];
      end
    end
  end
`else
  logic w_unused_stat_sel;

  assign stat_count        = '0;
  assign w_unused_stat_sel = ^stat_sel;
`endif

endmodule

`default_nettype wire
